debugger_value_bus_master: RTL and testbench

//  Host-side initiator for the debugger value bus (ena/wea/id/data). It decodes
//  a byte-stream command protocol from the host link, for example after a UART RX.
//  It issues one single-cycle read or write on the value bus per command.
//  It returns the response bytes on a valid/ready TX byte stream.
//  It sits between the host serial link and the CPU debugger value register blocks.

---
 rtl/debugger_value_bus_master.sv | 167 ++++++++++++++++
 tb/tb_debugger_value_bus_master.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/debugger_value_bus_master.sv
// Host-side initiator for the debugger value bus: decodes read/write command frames from a byte
// stream, issues one single-cycle bus access per frame and streams the response bytes back.
// Optional feature: define DBG_RX_TIMEOUT_EN to drop partial frames after TIMEOUT_CYCLES idle cycles.
module debugger_value_bus_master #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_valid,
  output logic        o_rx_ready,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_valid,
  input  logic        i_tx_ready,
  output logic        o_ena,
  output logic        o_wea,
  output logic [15:0] o_id,
  output logic [15:0] o_data,
  input  logic [15:0] i_data,
  output logic        o_busy,
  output logic [2:0]  o_dbg_state
);

  // Handshake: a byte moves on a rising edge where valid & ready are both high; the
  // sender holds data stable while valid & !ready.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ID_HI  = 3'd1,
    S_ID_LO  = 3'd2,
    S_DAT_HI = 3'd3,
    S_DAT_LO = 3'd4,
    S_ISSUE  = 3'd5,
    S_TX0    = 3'd6,
    S_TX1    = 3'd7
  } state_t;

  localparam logic [7:0] OP_READ  = 8'h01;
  localparam logic [7:0] OP_WRITE = 8'h02;
  localparam logic [7:0] RSP_ACK  = 8'hAA;
  localparam logic [7:0] RSP_ERR  = 8'hEE;

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  state_t      state_q, state_d;
  logic        is_write_q, is_write_d;
  logic [15:0] id_q, id_d;
  logic [15:0] data_q, data_d;
  logic [7:0]  rd_lo_q, rd_lo_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        rx_ready, rx_fire, tx_valid, tx_fire, timeout_hit;

  assign rx_ready = (state_q == S_IDLE) || (state_q == S_ID_HI) || (state_q == S_ID_LO) ||
                    (state_q == S_DAT_HI) || (state_q == S_DAT_LO);
  assign rx_fire  = i_rx_valid && rx_ready;
  assign tx_valid = (state_q == S_TX0) || (state_q == S_TX1);
  assign tx_fire  = tx_valid && i_tx_ready;

`ifdef DBG_RX_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  logic [CNT_W-1:0] to_cnt_q, to_cnt_d;
  logic             in_frame;

  assign in_frame = rx_ready && (state_q != S_IDLE);

  // Cleared by any accepted byte; only ticks while waiting inside a partial frame.
  always_comb begin
    to_cnt_d    = '0;
    timeout_hit = 1'b0;
    if (in_frame && !rx_fire) begin
      if (to_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) timeout_hit = 1'b1;
      else                                        to_cnt_d    = to_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) to_cnt_q <= '0;
    else            to_cnt_q <= to_cnt_d;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    is_write_d = is_write_q;
    id_d       = id_q;
    data_d     = data_q;
    rd_lo_d    = rd_lo_q;
    tx_data_d  = tx_data_q;
    case (state_q)
      S_IDLE: if (rx_fire) begin
        if ((i_rx_data == OP_READ) || (i_rx_data == OP_WRITE)) begin
          is_write_d = (i_rx_data == OP_WRITE);
          state_d    = S_ID_HI;
        end else begin
          tx_data_d = RSP_ERR;
          state_d   = S_TX1;
        end
      end
      S_ID_HI: if (rx_fire) begin
        id_d[15:8] = i_rx_data;
        state_d    = S_ID_LO;
      end
      S_ID_LO: if (rx_fire) begin
        id_d[7:0] = i_rx_data;
        state_d   = is_write_q ? S_DAT_HI : S_ISSUE;
      end
      S_DAT_HI: if (rx_fire) begin
        data_d[15:8] = i_rx_data;
        state_d      = S_DAT_LO;
      end
      S_DAT_LO: if (rx_fire) begin
        data_d[7:0] = i_rx_data;
        state_d     = S_ISSUE;
      end
      S_ISSUE: begin
        if (is_write_q) begin
          tx_data_d = RSP_ACK;
          state_d   = S_TX1;
        end else begin
          // Read data is only valid during this cycle; keep the low byte for TX1.
          rd_lo_d   = i_data[7:0];
          tx_data_d = i_data[15:8];
          state_d   = S_TX0;
        end
      end
      S_TX0: if (tx_fire) begin
        tx_data_d = rd_lo_q;
        state_d   = S_TX1;
      end
      S_TX1: if (tx_fire) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (timeout_hit) state_d = S_IDLE;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q    <= S_IDLE;
      is_write_q <= 1'b0;
      id_q       <= '0;
      data_q     <= '0;
      rd_lo_q    <= '0;
      tx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      is_write_q <= is_write_d;
      id_q       <= id_d;
      data_q     <= data_d;
      rd_lo_q    <= rd_lo_d;
      tx_data_q  <= tx_data_d;
    end
  end

  assign o_rx_ready  = rx_ready;
  assign o_tx_valid  = tx_valid;
  assign o_tx_data   = tx_data_q;
  assign o_ena       = (state_q == S_ISSUE);
  assign o_wea       = (state_q == S_ISSUE) && is_write_q;
  assign o_id        = id_q;
  assign o_data      = data_q;
  assign o_busy      = (state_q != S_IDLE);
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_debugger_value_bus_master.sv
// Bench for debugger_value_bus_master: directed and random command frames checked against a
// frame-level model of bus accesses and response bytes.
module tb_debugger_value_bus_master;

`ifdef DBG_RX_TIMEOUT_EN
  localparam int unsigned TO = 16;
`else
  localparam int unsigned TO = 1024;
`endif

  logic        i_clk = 1'b0;
  logic        i_reset_n;
  logic [7:0]  i_rx_data;
  logic        i_rx_valid;
  logic        o_rx_ready;
  logic [7:0]  o_tx_data;
  logic        o_tx_valid;
  logic        i_tx_ready;
  logic        o_ena;
  logic        o_wea;
  logic [15:0] o_id;
  logic [15:0] o_data;
  logic [15:0] i_data;
  logic        o_busy;
  logic [2:0]  o_dbg_state;

  logic [15:0] rd_val;
  logic [15:0] m_id, m_data;
  logic [7:0]  exp_q[$];
  logic [39:0] acc_exp_q[$];
  logic [39:0] acc_q[$];
  int          n_cmp = 0;
  int          n_fail = 0;

  debugger_value_bus_master #(.TIMEOUT_CYCLES(TO)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n),
    .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid), .o_rx_ready(o_rx_ready),
    .o_tx_data(o_tx_data), .o_tx_valid(o_tx_valid), .i_tx_ready(i_tx_ready),
    .o_ena(o_ena), .o_wea(o_wea), .o_id(o_id), .o_data(o_data),
    .i_data(i_data), .o_busy(o_busy), .o_dbg_state(o_dbg_state)
  );

  // Clock / reset
  always #5 i_clk = ~i_clk;

  // Bus slave: read data is only meaningful while the access is active.
  assign i_data = o_ena ? rd_val : 16'hDEAD;

  // Bus access monitor: one entry per cycle with o_ena high.
  always @(negedge i_clk)
    if (o_ena === 1'b1) acc_q.push_back({7'd0, o_wea, o_id, o_data});

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_rx_ready"}, o_rx_ready, 1'b1);
    chk({tag, "_tx_valid"}, o_tx_valid, 1'b0);
    chk({tag, "_tx_data"},  o_tx_data, 8'h00);
    chk({tag, "_ena"},      o_ena, 1'b0);
    chk({tag, "_wea"},      o_wea, 1'b0);
    chk({tag, "_id"},       o_id, 16'h0000);
    chk({tag, "_data"},     o_data, 16'h0000);
    chk({tag, "_busy"},     o_busy, 1'b0);
  endtask

  task automatic pulse_reset();
    i_reset_n = 1'b0;
    #1;
    check_reset_vals("rst_async");
    @(negedge i_clk);
    i_reset_n = 1'b1;
    @(posedge i_clk); #1;
  endtask

  // Driver: called on the posedge+1 grid, returns on it just after the accepting edge.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    repeat ($urandom_range(0, 2)) begin @(posedge i_clk); #1; end
    i_rx_data  = b;
    i_rx_valid = 1'b1;
    while (o_rx_ready !== 1'b1 && n < 200) begin @(negedge i_clk); n++; end
    if (n >= 200) chk("rx_ready_wait", o_rx_ready, 1'b1);
    @(posedge i_clk); #1;
    i_rx_valid = 1'b0;
    i_rx_data  = $urandom_range(0, 255);
  endtask

  task automatic recv_resp(input int n, input int first_stall);
    int          got = 0;
    int          cyc = 0;
    int          stall = first_stall;
    logic        holding = 1'b0;
    logic [7:0]  held = 8'h00;
    while (got < n && cyc < 300) begin
      if (stall > 0) begin i_tx_ready = 1'b0; stall--; end
      else i_tx_ready = ($urandom_range(0, 3) != 0);
      @(negedge i_clk);
      if (holding) begin
        chk("tx_valid_held", o_tx_valid, 1'b1);
        chk("tx_data_stable", o_tx_data, held);
      end
      holding = 1'b0;
      if (o_tx_valid === 1'b1) begin
        chk("rx_ready_in_tx", o_rx_ready, 1'b0);
        if (i_tx_ready) begin
          chk("tx_byte", o_tx_data, exp_q.pop_front());
          got++;
        end else begin
          holding = 1'b1;
          held    = o_tx_data;
        end
      end
      @(posedge i_clk); #1;
      cyc++;
    end
    i_tx_ready = 1'b0;
    if (got < n) chk("tx_byte_count", got, n);
  endtask

  // Frame-level model: builds the bytes, the expected bus access and the response.
  task automatic run_frame(input logic [7:0] op, input logic [15:0] id, input logic [15:0] dat,
                           input logic [15:0] rdv, input int first_stall, input int gap_last);
    logic [7:0] fr[$];
    logic       is_access;
    fr.push_back(op);
    rd_val = rdv;
    exp_q.delete();
    acc_exp_q.delete();
    acc_q.delete();
    is_access = (op == 8'h01) || (op == 8'h02);
    if (op == 8'h01) begin
      fr.push_back(id[15:8]); fr.push_back(id[7:0]);
      m_id = id;
      acc_exp_q.push_back({7'd0, 1'b0, id, m_data});
      exp_q.push_back(rdv[15:8]); exp_q.push_back(rdv[7:0]);
    end else if (op == 8'h02) begin
      fr.push_back(id[15:8]); fr.push_back(id[7:0]);
      fr.push_back(dat[15:8]); fr.push_back(dat[7:0]);
      m_id = id; m_data = dat;
      acc_exp_q.push_back({7'd0, 1'b1, id, dat});
      exp_q.push_back(8'hAA);
    end else begin
      exp_q.push_back(8'hEE);
    end
    for (int i = 0; i < fr.size(); i++) begin
      if (i == fr.size() - 1 && gap_last > 0) begin
        repeat (gap_last) begin @(posedge i_clk); #1; end
        chk("partial_busy", o_busy, 1'b1);
        chk("partial_rx_ready", o_rx_ready, 1'b1);
      end
      send_byte(fr[i]);
    end
    chk("last_byte_rx_ready", o_rx_ready, 1'b0);
    chk("last_byte_busy", o_busy, 1'b1);
    if (is_access) begin
      chk("ena_latency", o_ena, 1'b1);
      chk("tx_not_yet", o_tx_valid, 1'b0);
      @(posedge i_clk); #1;
      chk("ena_single", o_ena, 1'b0);
      chk("tx_latency", o_tx_valid, 1'b1);
    end else begin
      chk("err_no_ena", o_ena, 1'b0);
      chk("err_tx_valid", o_tx_valid, 1'b1);
    end
    recv_resp(exp_q.size(), first_stall);
    chk("done_busy", o_busy, 1'b0);
    chk("done_tx_valid", o_tx_valid, 1'b0);
    chk("acc_count", acc_q.size(), acc_exp_q.size());
    while (acc_q.size() > 0 && acc_exp_q.size() > 0)
      chk("bus_access", acc_q.pop_front(), acc_exp_q.pop_front());
    chk("id_kept", o_id, m_id);
    chk("data_kept", o_data, m_data);
  endtask

  initial begin
    logic [7:0] op;
    i_reset_n  = 1'b0;
    i_rx_data  = 8'h00;
    i_rx_valid = 1'b0;
    i_tx_ready = 1'b0;
    rd_val     = 16'h0000;
    m_id       = 16'h0000;
    m_data     = 16'h0000;
    repeat (3) @(posedge i_clk);
    #1;
    check_reset_vals("reset");
    @(negedge i_clk);
    i_reset_n = 1'b1;
    @(posedge i_clk); #1;

    // Basic read, basic write, unknown opcode followed by a normal read
    run_frame(8'h01, 16'h0008, 16'h0000, 16'h0042, 0, 0);
    run_frame(8'h02, 16'h0001, 16'h0001, 16'h0000, 0, 0);
    run_frame(8'h7F, 16'h0000, 16'h0000, 16'h0000, 0, 0);
    run_frame(8'h01, 16'h0002, 16'h0000, 16'h1234, 0, 0);

    // Back-pressure on the response
    run_frame(8'h01, 16'h0BCD, 16'h0000, 16'hC35A, 5, 0);

    // Stalled partial frame
`ifdef DBG_RX_TIMEOUT_EN
    acc_q.delete();
    send_byte(8'h01);
    send_byte(8'h00);
    m_id = {8'h00, m_id[7:0]};
    repeat (TO - 1) begin @(posedge i_clk); #1; end
    chk("to_busy_before", o_busy, 1'b1);
    @(posedge i_clk); #1;
    chk("to_busy_after", o_busy, 1'b0);
    chk("to_rx_ready", o_rx_ready, 1'b1);
    chk("to_tx_valid", o_tx_valid, 1'b0);
    chk("to_no_access", acc_q.size(), 0);
    run_frame(8'h01, 16'h0002, 16'h0000, 16'h7E81, 0, 0);
`else
    run_frame(8'h01, 16'h0005, 16'h0000, 16'h55AA, 0, 100);
`endif

    // Reset mid-frame
    acc_q.delete();
    send_byte(8'h02); send_byte(8'h00); send_byte(8'h01); send_byte(8'h00);
    pulse_reset();
    m_id = 16'h0000; m_data = 16'h0000;
    repeat (5) begin @(posedge i_clk); #1; end
    chk("rst_frame_no_access", acc_q.size(), 0);
    chk("rst_frame_no_tx", o_tx_valid, 1'b0);
    run_frame(8'h01, 16'h000E, 16'h0000, 16'hBEEF, 0, 0);

    // Reset mid-response
    rd_val = 16'hA5C3;
    send_byte(8'h01); send_byte(8'h12); send_byte(8'h34);
    @(posedge i_clk); #1;
    chk("rsp_pending", o_tx_valid, 1'b1);
    pulse_reset();
    m_id = 16'h0000; m_data = 16'h0000;
    repeat (5) begin @(posedge i_clk); #1; end
    chk("rst_rsp_no_tx", o_tx_valid, 1'b0);
    chk("rst_rsp_idle", o_busy, 1'b0);

    // All-ones id and data
    run_frame(8'h01, 16'hFFFF, 16'h0000, 16'hFFFF, 0, 0);
    run_frame(8'h02, 16'hFFFF, 16'hFFFF, 16'h0000, 0, 0);

    // Random frames
    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 4))
        0, 1: op = 8'h01;
        2, 3: op = 8'h02;
        default: begin
          op = 8'($urandom_range(0, 255));
          while (op == 8'h01 || op == 8'h02) op = 8'($urandom_range(0, 255));
        end
      endcase
      run_frame(op, 16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
                16'($urandom_range(0, 65535)), $urandom_range(0, 3), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
